// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array sequencer.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    DRAIN
  } state_t;

  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam int         BF16_W   = 16;
  localparam int         N_DEF    = 4;

  // Cycles between the last read and the first result: skew depth plus PE settle.
  function automatic int flush_cyc_f(input int n);
    return 2 * n + 1;
  endfunction

  localparam int FLUSH_CYC = flush_cyc_f(N_DEF);

endpackage

// File: rtl/skew_line.sv
// Per-lane operand delay line; DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_flush};
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [W-1:0] r_pipe [DEPTH];

      // NOTE: stages update with <= so every stage samples the previous stage's
      // old value; the line is tiny and must emit FP8 zeros after reset, so
      // unlike a RAM every stage is reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DEPTH; s++) r_pipe[s] <= '0;
        end else if (i_flush) begin
          for (int s = 0; s < DEPTH; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int s = 1; s < DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N output-stationary FP8 MAC array: operand fetch,
// edge skew, per-diagonal accumulator clear and a valid/ready result drain.
module systolic_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [KW-1:0]          cfg_k,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [KW-1:0]          rd_k,
  input  logic [8*N-1:0]         a_rd_data,
  input  logic [8*N-1:0]         b_rd_data,
  output logic [8*N-1:0]         a_feed,
  output logic [8*N-1:0]         b_feed,
  output logic [2*N-2:0]         pe_clear,
  output logic [$clog2(N)-1:0]   sel_row,
  output logic [$clog2(N)-1:0]   sel_col,
  input  logic [BF16_W-1:0]      sel_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BF16_W-1:0]      res_data
);

  localparam int SW      = $clog2(N);
  localparam int FW      = $clog2(2 * N + 2);
  localparam int IW      = 2 * SW;
  localparam int L_FLUSH = flush_cyc_f(N);

  state_t         r_state, w_next;
  logic [KW-1:0]  r_k, r_kmax;
  logic [FW-1:0]  r_flush;
  logic [IW-1:0]  r_idx;
  logic           r_done, r_rd_vld, r_first;
  logic [8*N-1:0] r_a_in, r_b_in;
  logic [2*N-2:0] r_clear;
  logic           w_accept, w_k_last, w_flush_last, w_idx_last, w_hs, w_abort;

  assign w_accept     = (r_state == IDLE) && start && (cfg_k != '0);
  assign w_k_last     = (r_k == r_kmax - KW'(1));
  assign w_flush_last = (r_flush == FW'(L_FLUSH - 1));
  assign w_idx_last   = (r_idx == IW'(N * N - 1));
  assign w_hs         = (r_state == DRAIN) && res_ready;
  assign w_abort      = abort && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept)           w_next = FETCH;
        FETCH:   if (w_k_last)           w_next = FLUSH;
        FLUSH:   if (w_flush_last)       w_next = DRAIN;
        DRAIN:   if (w_hs && w_idx_last) w_next = IDLE;
        default:                         w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != IDLE);
    rd_en     = (r_state == FETCH);
    rd_k      = (r_state == FETCH) ? r_k : '0;
    res_valid = (r_state == DRAIN);
    res_data  = (r_state == DRAIN) ? sel_data : '0;
  end

  assign done     = r_done;
  assign pe_clear = r_clear;
  assign sel_row  = r_idx[IW-1:SW];
  assign sel_col  = r_idx[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_kmax  <= '0;
      r_flush <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_abort) begin
        case (r_state)
          IDLE: begin
            if (start && cfg_k == '0) r_done <= 1'b1;
            if (w_accept) begin
              r_kmax  <= cfg_k;
              r_k     <= '0;
              r_flush <= '0;
              r_idx   <= '0;
            end
          end
          FETCH: if (!w_k_last) r_k <= r_k + KW'(1);
          FLUSH: r_flush <= w_flush_last ? '0 : r_flush + FW'(1);
          DRAIN: begin
            if (w_hs && w_idx_last) r_done <= 1'b1;
            else if (w_hs)          r_idx  <= r_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Input stage: read data is one cycle behind rd_en; idle lanes carry FP8 zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_first  <= 1'b0;
      r_a_in   <= '0;
      r_b_in   <= '0;
      r_clear  <= '0;
    end else if (w_abort) begin
      r_rd_vld <= 1'b0;
      r_first  <= 1'b0;
      r_a_in   <= '0;
      r_b_in   <= '0;
      r_clear  <= '0;
    end else begin
      r_rd_vld <= rd_en;
      r_first  <= rd_en && (r_k == '0);
      r_a_in   <= r_rd_vld ? a_rd_data : {N{FP8_ZERO}};
      r_b_in   <= r_rd_vld ? b_rd_data : {N{FP8_ZERO}};
      r_clear  <= {r_clear[2*N-3:0], r_first};
    end
  end

  generate
    for (genvar l = 0; l < N; l++) begin : g_lane
      skew_line #(.DEPTH(l), .W(8)) u_a_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_d     (r_a_in[8*l +: 8]),
        .o_q     (a_feed[8*l +: 8])
      );
      skew_line #(.DEPTH(l), .W(8)) u_b_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_d     (r_b_in[8*l +: 8]),
        .o_q     (b_feed[8*l +: 8])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: operand memories and a 4x4 PE array model around
// the DUT, with a result scoreboard fed by directed jobs.
module tb_systolic_seq_ctrl;
  import tpu_pkg::*;

  localparam int N  = 4;
  localparam int KW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic          busy, done, rd_en;
  logic [KW-1:0] rd_k;
  logic [8*N-1:0] a_rd_data = '0, b_rd_data = '0;
  logic [8*N-1:0] a_feed, b_feed;
  logic [2*N-2:0] pe_clear;
  logic [1:0]     sel_row, sel_col;
  logic [15:0]    sel_data;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [15:0]    res_data;

  systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_k     (cfg_k),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_k      (rd_k),
    .a_rd_data (a_rd_data),
    .b_rd_data (b_rd_data),
    .a_feed    (a_feed),
    .b_feed    (b_feed),
    .pe_clear  (pe_clear),
    .sel_row   (sel_row),
    .sel_col   (sel_col),
    .sel_data  (sel_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- operand memories ----------------
  logic [7:0] a_mem [512][N];
  logic [7:0] b_mem [512][N];

  always @(posedge clk) begin
    for (int l = 0; l < N; l++) begin
      a_rd_data[8*l +: 8] <= rd_en ? a_mem[rd_k][l] : 8'h38;
      b_rd_data[8*l +: 8] <= rd_en ? b_mem[rd_k][l] : 8'h38;
    end
  end

  // mode 0: zeros, 1: all 1.0, 2: A=2.0 on diagonal/B=1.0, 3: lower/upper triangles of 1.0
  task automatic set_mem(input int mode);
    for (int k = 0; k < 512; k++) begin
      for (int l = 0; l < N; l++) begin
        case (mode)
          0:       begin a_mem[k][l] = 8'h00; b_mem[k][l] = 8'h00; end
          1:       begin a_mem[k][l] = 8'h38; b_mem[k][l] = 8'h38; end
          2:       begin a_mem[k][l] = (k == l) ? 8'h40 : 8'h00; b_mem[k][l] = 8'h38; end
          default: begin a_mem[k][l] = (k <= l) ? 8'h38 : 8'h00; b_mem[k][l] = (k <= l) ? 8'h38 : 8'h00; end
        endcase
      end
    end
  endtask

  // ---------------- PE array model (integer-valued FP8 / BF16 only) ----------------
  function automatic int fp8_val(input logic [7:0] x);
    if (x[6:0] == 7'd0) return 0;
    return ((8 + int'(x[2:0])) << x[6:3]) >> 10;
  endfunction

  function automatic logic [15:0] bf16_of(input int v);
    int e;
    int man;
    if (v == 0) return 16'h0000;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    man = (e >= 7) ? (v >> (e - 7)) : (v << (7 - e));
    return {1'b0, 8'(e + 127), man[6:0]};
  endfunction

  int       acc [N][N];
  bit [7:0] a_h [N][N];
  bit [7:0] b_v [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [7:0] a_in, b_in;
        int p;
        if (j == 0) a_in = a_feed[8*i +: 8]; else a_in = a_h[i][j-1];
        if (i == 0) b_in = b_feed[8*j +: 8]; else b_in = b_v[i-1][j];
        p = fp8_val(a_in) * fp8_val(b_in);
        acc[i][j] <= pe_clear[i+j] ? p : acc[i][j] + p;
        a_h[i][j] <= a_in;
        b_v[i][j] <= b_in;
      end
    end
  end

  assign sel_data = bf16_of(acc[sel_row][sel_col]);

  // ---------------- ready driver ----------------
  bit bp_mode = 1'b0;
  int phase   = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = bp_mode ? (phase == 0 || phase == 3) : 1'b1;
      phase     = (phase + 1) % 4;
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   last_hs = 1'b0;

  task automatic push_const(input logic [15:0] v);
    for (int x = 0; x < N * N; x++) exp_q.push_back('{idx: 4'(x), data: v});
  endtask

  task automatic push_tri();
    logic [15:0] tab [4];
    tab[0] = 16'h3F80; tab[1] = 16'h4000; tab[2] = 16'h4040; tab[3] = 16'h4080;
    for (int x = 0; x < N * N; x++) begin
      int i, j;
      i = x / N;
      j = x % N;
      exp_q.push_back('{idx: 4'(x), data: tab[(i < j) ? i : j]});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (last_hs) check("done_after_last_handshake", done, 1);
    last_hs = 1'b0;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got idx %0h data %0h, expected none", {sel_row, sel_col}, res_data);
      end else begin
        e = exp_q.pop_front();
        check("res_idx", {sel_row, sel_col}, e.idx);
        check("res_data", res_data, e.data);
        if (exp_q.size() == 0) last_hs = 1'b1;
      end
    end
  end

  // ---------------- job driver ----------------
  function automatic logic [18:0] exp_ctrl(input int m, input int k);
    logic          rden;
    logic [KW-1:0] rdk;
    logic [6:0]    clr;
    rden = (m <= k);
    rdk  = rden ? KW'(m - 1) : '0;
    clr  = (m >= 3 && m <= 9) ? 7'(1 << (m - 3)) : 7'd0;
    return {1'b1, rden, rdk, clr, (m == k + 10)};
  endfunction

  function automatic logic [127:0] all_outs();
    return {busy, done, rd_en, rd_k, a_feed, b_feed, pe_clear, sel_row, sel_col, res_valid, res_data};
  endfunction

  task automatic run_job(input int k, input bit bp, input bit start_in_drain, input bit chk_len);
    int done_at;
    done_at = -1;
    bp_mode = bp;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_k = KW'(k);
    for (int m = 0; m < k + 200; m++) begin
      @(negedge clk);
      if (m >= 1 && m <= k + 10)
        check($sformatf("ctrl_k%0d_m%0d", k, m), {busy, rd_en, rd_k, pe_clear, res_valid}, exp_ctrl(m, k));
      if (done_at >= 0) begin
        check("idle_after_done", {done, busy, rd_en}, 3'b000);
        break;
      end
      if (done) done_at = m;
      @(posedge clk); #1;
      start = start_in_drain && (m + 1 == k + 12);
      cfg_k = KW'(3);
    end
    start   = 1'b0;
    bp_mode = 1'b0;
    if (done_at < 0) check("done_timeout", 0, 1);
    else if (chk_len) check($sformatf("done_cycle_k%0d", k), done_at, k + 26);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_mem(1);
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, rd_en}, 3'b000);

    // reset in the middle of FETCH
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 9'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_fetch_outputs", all_outs(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_mid_reset", {busy, rd_en}, 2'b00);

    // diagonal 2.0 x ones
    set_mem(2);
    push_const(16'h4000);
    run_job(4, 1'b0, 1'b0, 1'b1);

    // back-to-back jobs: accumulation must restart
    set_mem(1);
    push_const(16'h3F80);
    run_job(1, 1'b0, 1'b0, 1'b1);
    push_const(16'h4040);
    run_job(3, 1'b0, 1'b0, 1'b1);

    // backpressure with distinct values, plus a start issued during DRAIN
    set_mem(3);
    push_tri();
    run_job(4, 1'b1, 1'b1, 1'b0);

    // abort at T0+2 of a K=8 job
    set_mem(1);
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 9'd8;
    @(negedge clk);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk);
    check("busy_before_abort_edge", busy, 1);
    @(posedge clk); #1; abort = 1'b0;
    for (int m = 3; m < 16; m++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_m%0d", m), {busy, done, rd_en, pe_clear, a_feed, b_feed}, 0);
    end
    push_const(16'h3F80);
    run_job(1, 1'b0, 1'b0, 1'b1);

    // cfg_k = 0: done on T0+1, no reads
    @(posedge clk); #1;
    start = 1'b1; cfg_k = 9'd0;
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      check($sformatf("zero_k_m%0d", m), {done, busy, rd_en}, {(m == 1), 2'b00});
      @(posedge clk); #1; start = 1'b0;
    end

    // maximum K with zero operands: results must clear to zero
    set_mem(0);
    push_const(16'h0000);
    run_job(511, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
